// File: rtl/mips_alu_mdu.sv
// rtl/mips_alu_mdu.sv - EX-stage ALU with registered results and an optional iterative multiply/divide unit.
// Build option: define ALU_MULDIV_EN to build the MDU; otherwise ops 11-14 return 0 like reserved ops.
module mips_alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic             zero
);
    localparam int SHAMT_W = $clog2(WIDTH);

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, RESP} state_t;
`endif

    state_t               state;
    logic [3:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     simple_res;
    logic [SHAMT_W-1:0]   shamt;

    assign in_ready = !rst && (state == IDLE);
    assign shamt    = a_q[SHAMT_W-1:0];

    // Simple ops are evaluated from the captured operands one cycle after acceptance.
    always_comb begin
        simple_res = '0;
        case (op_q)
            4'd0:  simple_res = a_q & b_q;
            4'd1:  simple_res = a_q | b_q;
            4'd2:  simple_res = a_q + b_q;
            4'd3:  simple_res = a_q ^ b_q;
            4'd4:  simple_res = b_q << shamt;
            4'd5:  simple_res = b_q >> shamt;
            4'd6:  simple_res = a_q - b_q;
            4'd7:  simple_res[0] = ($signed(a_q) < $signed(b_q));
            4'd8:  simple_res[0] = (a_q < b_q);
            4'd9:  simple_res = ~(a_q | b_q);
            4'd10: simple_res = $signed(b_q) >>> shamt;
            default: simple_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic [SHAMT_W-1:0]   cnt;
    logic [WIDTH-1:0]     acc_hi;
    logic [WIDTH-1:0]     acc_lo;
    logic [WIDTH-1:0]     bm;
    logic                 is_div_q;
    logic                 neg_q;
    logic                 rneg_q;
    logic                 in_mdu;
    logic                 in_signed;
    logic                 in_na;
    logic                 in_nb;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_rs;
    logic [WIDTH:0]       div_trial;
    logic [WIDTH-1:0]     step_hi;
    logic [WIDTH-1:0]     step_lo;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     fin_out;
    logic [WIDTH-1:0]     fin_hi;

    assign in_mdu    = (op >= 4'd11) && (op <= 4'd14);
    assign in_signed = (op == 4'd11) || (op == 4'd13);
    assign in_na     = in_signed && in1[WIDTH-1];
    assign in_nb     = in_signed && in2[WIDTH-1];

    // acc_hi:acc_lo is the running product (multiplier shifts out of acc_lo) or remainder:quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, bm} : '0);
        div_rs    = {acc_hi, acc_lo[WIDTH-1]};
        div_trial = div_rs - {1'b0, bm};
        if (is_div_q) begin
            step_hi = div_trial[WIDTH] ? div_rs[WIDTH-1:0] : div_trial[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], ~div_trial[WIDTH]};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
        prod = {step_hi, step_lo};
        if (neg_q)
            prod = -prod;
        if (is_div_q) begin
            if (b_q == '0) begin
                fin_out = '1;
                fin_hi  = a_q;
            end else begin
                fin_out = neg_q  ? -step_lo : step_lo;
                fin_hi  = rneg_q ? -step_hi : step_hi;
            end
        end else begin
            fin_out = prod[WIDTH-1:0];
            fin_hi  = prod[2*WIDTH-1:WIDTH];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out       <= '0;
            hi        <= '0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
`ifdef ALU_MULDIV_EN
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            bm        <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= op;
                        a_q  <= in1;
                        b_q  <= in2;
`ifdef ALU_MULDIV_EN
                        if (in_mdu) begin
                            cnt      <= '0;
                            acc_hi   <= '0;
                            acc_lo   <= in_na ? -in1 : in1;
                            bm       <= in_nb ? -in2 : in2;
                            is_div_q <= (op == 4'd13) || (op == 4'd14);
                            neg_q    <= in_na ^ in_nb;
                            rneg_q   <= in_na;
                            state    <= BUSY;
                        end else begin
                            state <= RESP;
                        end
`else
                        state <= RESP;
`endif
                    end
                end
`ifdef ALU_MULDIV_EN
                BUSY: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == SHAMT_W'(WIDTH - 1)) begin
                        out       <= fin_out;
                        hi        <= fin_hi;
                        zero      <= (fin_out == '0);
                        out_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
`endif
                RESP: begin
                    if (!out_valid) begin
                        out       <= simple_res;
                        hi        <= '0;
                        zero      <= (simple_res == '0);
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_alu_mdu.sv
// tb/tb_mips_alu_mdu.sv - Self-checking bench for mips_alu_mdu against an arithmetic reference model.
module tb_mips_alu_mdu;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [3:0]    op = 4'd0;
    logic [W-1:0]  in1 = '0;
    logic [W-1:0]  in2 = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out;
    logic [W-1:0]  hi;
    logic          zero;

    int n_cmp = 0;
    int n_bad = 0;

    mips_alu_mdu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .hi        (hi),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [31:0] h);
        int          sa;
        int          sb;
        logic [4:0]  s;
        logic [63:0] p;
        sa = a;
        sb = b;
        s  = a[4:0];
        r  = '0;
        h  = '0;
        p  = '0;
        case (o)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a + b;
            4'd3:  r = a ^ b;
            4'd4:  r = b << s;
            4'd5:  r = b >> s;
            4'd6:  r = a - b;
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  r = (a < b) ? 32'd1 : 32'd0;
            4'd9:  r = ~(a | b);
            4'd10: r = 32'(sb >>> s);
`ifdef ALU_MULDIV_EN
            4'd11: begin
                p = 64'(longint'(sa) * longint'(sb));
                r = p[31:0];
                h = p[63:32];
            end
            4'd12: begin
                p = {32'd0, a} * {32'd0, b};
                r = p[31:0];
                h = p[63:32];
            end
            4'd13: begin
                if (b == 0) begin
                    r = 32'hFFFF_FFFF;
                    h = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r = a;
                    h = 0;
                end else begin
                    r = 32'(sa / sb);
                    h = 32'(sa % sb);
                end
            end
            4'd14: begin
                if (b == 0) begin
                    r = 32'hFFFF_FFFF;
                    h = a;
                end else begin
                    r = a / b;
                    h = a % b;
                end
            end
`endif
            default: ;
        endcase
    endfunction

    function automatic int exp_latency(input logic [3:0] o);
`ifdef ALU_MULDIV_EN
        return (o >= 4'd11 && o <= 4'd14) ? W : 1;
`else
        return (o == o) ? 1 : 1;
`endif
    endfunction

    task automatic run(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit intrude);
        logic [31:0] er;
        logic [31:0] eh;
        int          lat;
        model(o, a, b, er, eh);
        @(negedge clk);
        check({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        op  = o;
        in1 = a;
        in2 = b;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in1 = $urandom;
        in2 = $urandom;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_latency(o)));
        check({tag, " out"}, 64'(out), 64'(er));
        check({tag, " hi"}, 64'(hi), 64'(eh));
        check({tag, " zero"}, 64'(zero), 64'(er == 0));
        if (intrude) begin
            in_valid = 1'b1;
            op  = 4'd2;
            in1 = 32'h1234;
            in2 = 32'h1;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " hold valid"}, 64'(out_valid), 64'd1);
            check({tag, " hold ready"}, 64'(in_ready), 64'd0);
            check({tag, " hold out"}, {hi, out}, {eh, er});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, " consumed valid"}, 64'(out_valid), 64'd0);
        check({tag, " consumed ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] pick [4];
        logic [31:0] ra;
        logic [31:0] rb;
        int          ncyc;
        pick[0] = 32'h0;
        pick[1] = 32'h1;
        pick[2] = 32'hFFFF_FFFF;
        pick[3] = 32'h8000_0000;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset out", 64'(out), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset zero", 64'(zero), 64'd1);
        check("reset valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post reset in_ready", 64'(in_ready), 64'd1);

        run("add wrap", 4'd2, 32'h7FFF_FFFF, 32'h1, 0, 1'b0);
        run("sub zero", 4'd6, 32'd5, 32'd5, 0, 1'b0);
        run("sra", 4'd10, 32'd4, 32'hF000_0000, 0, 1'b0);
        run("srl", 4'd5, 32'd4, 32'hF000_0000, 0, 1'b0);
        run("slt", 4'd7, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        run("sltu", 4'd8, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        run("mult", 4'd11, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
        run("multu", 4'd12, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);
        run("div neg", 4'd13, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run("div by 0", 4'd13, 32'd9, 32'd0, 0, 1'b0);
        run("div min", 4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run("hold", 4'd3, 32'hA5A5_0000, 32'h0F0F_F0F0, 5, 1'b1);
        run("reserved", 4'd15, 32'h55, 32'h66, 1, 1'b0);

        // Abort a divide with reset part-way through.
        @(negedge clk);
        in_valid = 1'b1;
        op  = 4'd14;
        in1 = 32'd1000;
        in2 = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort valid in rst", 64'(out_valid), 64'd0);
        check("abort in_ready in rst", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort in_ready after", 64'(in_ready), 64'd1);
        ncyc = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk);
            #1;
            if (out_valid)
                ncyc++;
        end
        check("abort no result", 64'(ncyc), 64'd0);
        run("add after abort", 4'd2, 32'd40, 32'd2, 0, 1'b0);

        for (int t = 0; t < 150; t++) begin
            ra = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 32'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 32'($urandom);
            if ($urandom_range(0, 7) == 0)
                rb = ra;
            run($sformatf("rnd%0d", t), 4'($urandom_range(0, 15)), ra, rb,
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
